bmem_arbiter: RTL and testbench

Shares the single 64-bit burst memory port between the instruction cache and data cache. Each cache issues whole 256-bit cache-line reads (icache, dcache) or writes (dcache only). The arbiter picks one requester with round-robin priority and sequences the 4-beat bmem burst. It then returns the assembled line with a one-cycle response pulse. It sits between the two cache miss paths and the `dut` side of the bmem interface.

---
 rtl/bmem_arbiter_if.sv | 46 ++++
 rtl/bmem_arbiter.sv | 128 ++++++++++++
 tb/tb_bmem_arbiter.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : bmem_arbiter_if
// Purpose  : Cache-miss request ports plus the dut side of the burst memory.
// Revision : 1.0 - initial release
// ============================================================================
interface bmem_arbiter_if #(
    parameter int BEATS = 4
);
    localparam int LINE_W = 64 * BEATS;

    logic [31:0]       i_addr;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic [31:0]       d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [63:0]       bmem_wdata;
    logic [63:0]       bmem_rdata;
    logic              bmem_resp;

    // slave: the arbiter itself; master: caches plus memory as seen by a bench
    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
        input  bmem_rdata, bmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
        output bmem_rdata, bmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/bmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bmem_arbiter
// Purpose  : Round-robin icache/dcache arbiter sequencing 4-beat bmem bursts.
// Revision : 1.0 - initial release
// ============================================================================
module bmem_arbiter #(
    parameter int BEATS = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    bmem_arbiter_if.slave  bus
);
    localparam int         LINE_W    = 64 * BEATS;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);
    localparam logic       OWN_I     = 1'b0;
    localparam logic       OWN_D     = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state_q,  state_d;
    logic [1:0]        beat_q,   beat_d;
    logic              owner_q,  owner_d;
    logic              last_q,   last_d;
    logic [31:0]       addr_q,   addr_d;
    logic [LINE_W-1:0] line_q,   line_d;
    logic [LINE_W-1:0] irdata_q, irdata_d;
    logic [LINE_W-1:0] drdata_q, drdata_d;

    logic                      w_i_pend;
    logic                      w_d_pend;
    logic                      w_grant_d;
    logic [$clog2(LINE_W)-1:0] w_beat_lsb;

    assign w_i_pend   = bus.i_read;
    assign w_d_pend   = bus.d_read | bus.d_write;
    // On a tie, dcache wins only if icache was the previous owner
    assign w_grant_d  = w_d_pend && (!w_i_pend || (last_q == OWN_I));
    assign w_beat_lsb = {beat_q, 6'b0};

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        owner_d  = owner_q;
        last_d   = last_q;
        addr_d   = addr_q;
        line_d   = line_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;

        case (state_q)
            IDLE: begin
                if (w_i_pend || w_d_pend) begin
                    owner_d = w_grant_d ? OWN_D : OWN_I;
                    addr_d  = (w_grant_d ? bus.d_addr : bus.i_addr) & ~32'h1F;
                    beat_d  = 2'd0;
                    state_d = (w_grant_d && bus.d_write) ? WR_BURST : RD_BURST;
                end
            end
            RD_BURST: begin
                if (bus.bmem_resp) begin
                    line_d[w_beat_lsb +: 64] = bus.bmem_rdata;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                        // Publish the full line so it is visible during DONE
                        if (owner_q == OWN_D) begin
                            drdata_d = line_d;
                        end else begin
                            irdata_d = line_d;
                        end
                    end
                end
            end
            WR_BURST: begin
                if (bus.bmem_resp) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= 2'd0;
            owner_q  <= OWN_I;
            last_q   <= OWN_D;
            addr_q   <= '0;
            line_q   <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            line_q   <= line_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign bus.bmem_read  = (state_q == RD_BURST);
    assign bus.bmem_write = (state_q == WR_BURST);
    assign bus.bmem_addr  = addr_q;
    assign bus.bmem_wdata = (state_q == WR_BURST) ? bus.d_wdata[w_beat_lsb +: 64] : 64'd0;
    assign bus.i_resp     = (state_q == DONE) && (owner_q == OWN_I);
    assign bus.d_resp     = (state_q == DONE) && (owner_q == OWN_D);
    assign bus.i_rdata    = irdata_q;
    assign bus.d_rdata    = drdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmem_arbiter
// Purpose  : Scoreboard bench for bmem_arbiter with a stallable burst memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bmem_arbiter;
    localparam int BEATS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bmem_arbiter_if #(.BEATS(BEATS)) bus ();

    bmem_arbiter #(.BEATS(BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         is_d;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } txn_t;

    typedef struct {
        logic         timeout;
        int           cycles;
        logic         got_i;
        logic         got_d;
        logic [255:0] i_rdata;
        logic [255:0] d_rdata;
        logic [31:0]  addr;
        logic         wr;
        logic [255:0] wline;
    } obs_t;

    txn_t         exp_q[$];
    logic [255:0] model_i;
    logic [255:0] model_d;
    int           n_checks;
    int           n_fail;

    logic [63:0]  rd_beats [4];
    int           gap;
    int           mem_cnt;
    int           gap_cnt;
    logic [31:0]  mem_addr;
    logic         mem_wr;
    logic [255:0] mem_wline;

    // Memory acts on what it saw at the edge and answers one cycle later
    always @(posedge clk) begin : mem_model
        logic        act;
        logic        was_resp;
        logic [63:0] wd;
        logic [31:0] ad;
        logic        isw;
        act      = bus.bmem_read || bus.bmem_write;
        was_resp = bus.bmem_resp;
        wd       = bus.bmem_wdata;
        ad       = bus.bmem_addr;
        isw      = bus.bmem_write;
        if (rst || !act) begin
            mem_cnt = 0;
            gap_cnt = 0;
        end else if (was_resp === 1'b1) begin
            if (mem_cnt == 0) begin
                mem_addr  = ad;
                mem_wr    = isw;
                mem_wline = '0;
            end
            mem_wline[64*mem_cnt +: 64] = wd;
            mem_cnt = mem_cnt + 1;
            gap_cnt = 0;
        end
        #1;
        if (!rst && act && mem_cnt < 4 && gap_cnt >= gap) begin
            bus.bmem_resp  = 1'b1;
            bus.bmem_rdata = rd_beats[mem_cnt];
        end else begin
            bus.bmem_resp  = 1'b0;
            bus.bmem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
            if (!rst && act && mem_cnt < 4) gap_cnt = gap_cnt + 1;
        end
    end

    function automatic txn_t mk(input logic is_d, input logic wr,
                                input logic [31:0] addr, input logic [255:0] line);
        txn_t t;
        t.is_d = is_d;
        t.wr   = wr;
        t.addr = addr;
        t.line = line;
        return t;
    endfunction

    // Waits for a resp pulse (edge count from the request-sampling edge) and pops the scoreboard
    task automatic collect(output txn_t e, output obs_t o);
        o.timeout = 1'b1;
        o.cycles  = -1;
        o.got_i   = 1'b0;
        o.got_d   = 1'b0;
        o.i_rdata = '0;
        o.d_rdata = '0;
        o.addr    = '0;
        o.wr      = 1'b0;
        o.wline   = '0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #2;
            if (bus.i_resp === 1'b1 || bus.d_resp === 1'b1) begin
                o.timeout = 1'b0;
                o.cycles  = c;
                o.got_i   = bus.i_resp;
                o.got_d   = bus.d_resp;
                o.i_rdata = bus.i_rdata;
                o.d_rdata = bus.d_rdata;
                o.addr    = mem_addr;
                o.wr      = mem_wr;
                o.wline   = mem_wline;
                break;
            end
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = mk(1'b0, 1'b0, 32'h0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if ({bus.bmem_read, bus.bmem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rd/wr/iresp/dresp=%b, want 0000",
                     {bus.bmem_read, bus.bmem_write, bus.i_resp, bus.d_resp});
        end
        n_checks++;
        if (bus.bmem_addr !== 32'h0 || bus.bmem_wdata !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%h wdata=%h, want 0", bus.bmem_addr, bus.bmem_wdata);
        end
        n_checks++;
        if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got i=%h d=%h, want 0", bus.i_rdata, bus.d_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_icache_read();
        txn_t e;
        obs_t o;
        rd_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                     64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        gap = 0;
        @(posedge clk); #1;
        bus.i_addr = 32'h6000_0024;
        bus.i_read = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h6000_0020,
            {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}));
        collect(e, o);
        n_checks++;
        if (o.timeout || o.got_i !== 1'b1 || o.got_d !== 1'b0) begin
            n_fail++;
            $display("FAIL icache_resp: got timeout=%0b i=%b d=%b, want i=1 d=0", o.timeout, o.got_i, o.got_d);
        end
        n_checks++;
        if (o.cycles != 5) begin
            n_fail++;
            $display("FAIL icache_latency: got %0d cycles, want 5", o.cycles);
        end
        n_checks++;
        if (o.addr !== e.addr || o.wr !== 1'b0) begin
            n_fail++;
            $display("FAIL icache_addr: got %h wr=%b, want %h wr=0", o.addr, o.wr, e.addr);
        end
        n_checks++;
        if (o.i_rdata !== e.line) begin
            n_fail++;
            $display("FAIL icache_rdata: got %h, want %h", o.i_rdata, e.line);
        end
        n_checks++;
        if (o.d_rdata !== model_d) begin
            n_fail++;
            $display("FAIL icache_d_untouched: got %h, want %h", o.d_rdata, model_d);
        end
        model_i = e.line;
        @(posedge clk); #1;
        bus.i_read = 1'b0;
        #1;
        n_checks++;
        if (bus.i_resp !== 1'b0 || bus.i_rdata !== model_i) begin
            n_fail++;
            $display("FAIL icache_pulse_hold: got resp=%b rdata=%h, want resp=0 rdata=%h",
                     bus.i_resp, bus.i_rdata, model_i);
        end
    endtask

    // Shared by the plain write and the read+write conflict cases
    task automatic run_dwrite(input string name, input logic also_read,
                              input logic [31:0] addr, input logic [255:0] wd);
        txn_t e;
        obs_t o;
        @(posedge clk); #1;
        bus.d_addr  = addr;
        bus.d_wdata = wd;
        bus.d_write = 1'b1;
        bus.d_read  = also_read;
        exp_q.push_back(mk(1'b1, 1'b1, addr & ~32'h1F, wd));
        collect(e, o);
        n_checks++;
        if (o.timeout || o.got_d !== 1'b1 || o.got_i !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_resp: got timeout=%0b i=%b d=%b, want d=1", name, o.timeout, o.got_i, o.got_d);
        end
        n_checks++;
        if (o.wr !== 1'b1 || o.addr !== e.addr) begin
            n_fail++;
            $display("FAIL %s_burst: got wr=%b addr=%h, want wr=1 addr=%h", name, o.wr, o.addr, e.addr);
        end
        n_checks++;
        if (o.wline !== e.line) begin
            n_fail++;
            $display("FAIL %s_beats: got %h, want %h", name, o.wline, e.line);
        end
        n_checks++;
        if (o.i_rdata !== model_i || o.d_rdata !== model_d) begin
            n_fail++;
            $display("FAIL %s_rdata_kept: got i=%h d=%h, want i=%h d=%h",
                     name, o.i_rdata, o.d_rdata, model_i, model_d);
        end
        @(posedge clk); #1;
        bus.d_write = 1'b0;
        bus.d_read  = 1'b0;
        #1;
        n_checks++;
        if (bus.d_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: got d_resp=%b after one cycle, want 0", name, bus.d_resp);
        end
    endtask

    task automatic test_dcache_write();
        run_dwrite("dwrite", 1'b0, 32'h8000_1234,
            {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
             64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000});
    endtask

    task automatic test_conflict();
        run_dwrite("conflict", 1'b1, 32'h0000_0ABC,
            {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
             64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_0F0F_F0F0});
    endtask

    task automatic test_stall();
        txn_t         e;
        logic [255:0] wd;
        logic         seen_w;
        logic         hold_ok;
        logic         wdata_ok;
        logic         done;
        int           cyc;
        wd = {64'h4000_0000_0000_0004, 64'h3000_0000_0000_0003,
              64'h2000_0000_0000_0002, 64'h1000_0000_0000_0001};
        gap      = 3;
        seen_w   = 1'b0;
        hold_ok  = 1'b1;
        wdata_ok = 1'b1;
        done     = 1'b0;
        cyc      = -1;
        @(posedge clk); #1;
        bus.d_addr  = 32'h0000_4000;
        bus.d_wdata = wd;
        bus.d_write = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b1, 32'h0000_4000, wd));
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #2;
            if (bus.d_resp === 1'b1) begin
                done = 1'b1;
                cyc  = c;
                break;
            end
            if (bus.bmem_write === 1'b1) seen_w = 1'b1;
            else if (seen_w) hold_ok = 1'b0;
            if (seen_w && mem_cnt < 4 && bus.bmem_wdata !== wd[64*mem_cnt +: 64]) wdata_ok = 1'b0;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (!done || cyc != 17) begin
            n_fail++;
            $display("FAIL stall_resp: got done=%0b after %0d cycles, want done=1 after 17", done, cyc);
        end
        n_checks++;
        if (!seen_w || !hold_ok) begin
            n_fail++;
            $display("FAIL stall_write_held: got seen=%0b held=%0b, want 1 1", seen_w, hold_ok);
        end
        n_checks++;
        if (!wdata_ok) begin
            n_fail++;
            $display("FAIL stall_wdata: got a beat that changed before acceptance, want each beat held");
        end
        n_checks++;
        if (mem_wline !== e.line) begin
            n_fail++;
            $display("FAIL stall_beats: got %h, want %h", mem_wline, e.line);
        end
        @(posedge clk); #1;
        bus.d_write = 1'b0;
        gap = 0;
    endtask

    task automatic test_simultaneous();
        txn_t         e;
        obs_t         o;
        logic [255:0] ln;
        rd_beats = '{64'hA0A0_0000_0000_0001, 64'hB1B1_0000_0000_0002,
                     64'hC2C2_0000_0000_0003, 64'hD3D3_0000_0000_0004};
        ln = {64'hD3D3_0000_0000_0004, 64'hC2C2_0000_0000_0003,
              64'hB1B1_0000_0000_0002, 64'hA0A0_0000_0000_0001};
        gap = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.i_addr = 32'h1000_0040;
        bus.d_addr = 32'h2000_007F;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        model_i = '0;
        model_d = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h1000_0040, ln));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h2000_0060, ln));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h1000_0040, ln));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h2000_0060, ln));
        for (int k = 0; k < 4; k++) begin
            collect(e, o);
            n_checks++;
            if (o.timeout || o.got_d !== e.is_d || o.got_i !== !e.is_d) begin
                n_fail++;
                $display("FAIL sim_grant%0d: got i=%b d=%b timeout=%0b, want d=%b",
                         k, o.got_i, o.got_d, o.timeout, e.is_d);
            end
            n_checks++;
            if (o.addr !== e.addr) begin
                n_fail++;
                $display("FAIL sim_addr%0d: got %h, want %h", k, o.addr, e.addr);
            end
            n_checks++;
            if ((e.is_d ? o.d_rdata : o.i_rdata) !== e.line) begin
                n_fail++;
                $display("FAIL sim_rdata%0d: got %h, want %h", k, e.is_d ? o.d_rdata : o.i_rdata, e.line);
            end
            @(posedge clk); #1;
            if (e.is_d) bus.d_read = 1'b0;
            else bus.i_read = 1'b0;
            if (k < 2) begin
                @(posedge clk); #1;
                if (e.is_d) bus.d_read = 1'b1;
                else bus.i_read = 1'b1;
            end
        end
        model_i = ln;
        model_d = ln;
    endtask

    task automatic test_reset_mid_burst();
        txn_t         e;
        obs_t         o;
        logic         reached;
        logic         saw_resp;
        logic [255:0] ln;
        rd_beats = '{64'h0000_0001_0000_0001, 64'h0000_0002_0000_0002,
                     64'h0000_0003_0000_0003, 64'h0000_0004_0000_0004};
        ln = {64'h0000_0004_0000_0004, 64'h0000_0003_0000_0003,
              64'h0000_0002_0000_0002, 64'h0000_0001_0000_0001};
        gap = 0;
        reached = 1'b0;
        @(posedge clk); #1;
        bus.i_addr = 32'h3000_0108;
        bus.i_read = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #2;
            if (mem_cnt == 2) begin
                reached = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!reached) begin
            n_fail++;
            $display("FAIL rstmid_progress: got beats=%0d, want 2 accepted", mem_cnt);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.bmem_read, bus.bmem_write, bus.i_resp, bus.d_resp} !== 4'b0000 ||
            bus.bmem_addr !== 32'h0 || bus.bmem_wdata !== 64'h0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got ctl=%b addr=%h wdata=%h, want all 0",
                     {bus.bmem_read, bus.bmem_write, bus.i_resp, bus.d_resp}, bus.bmem_addr, bus.bmem_wdata);
        end
        n_checks++;
        if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
            n_fail++;
            $display("FAIL rstmid_rdata: got i=%h d=%h, want 0", bus.i_rdata, bus.d_rdata);
        end
        bus.i_read = 1'b0;
        saw_resp = 1'b0;
        repeat (3) begin
            @(posedge clk); #2;
            if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) saw_resp = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #2;
            if (bus.i_resp !== 1'b0 || bus.d_resp !== 1'b0) saw_resp = 1'b1;
        end
        n_checks++;
        if (saw_resp) begin
            n_fail++;
            $display("FAIL rstmid_no_resp: got a resp pulse after abandoned burst, want none");
        end
        model_i = '0;
        model_d = '0;
        @(posedge clk); #1;
        bus.i_read = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h3000_0100, ln));
        collect(e, o);
        n_checks++;
        if (o.timeout || o.got_i !== 1'b1 || o.cycles != 5) begin
            n_fail++;
            $display("FAIL rstmid_fresh_resp: got i=%b timeout=%0b cycles=%0d, want i=1 cycles=5",
                     o.got_i, o.timeout, o.cycles);
        end
        n_checks++;
        if (o.i_rdata !== e.line || o.addr !== e.addr || o.d_rdata !== model_d) begin
            n_fail++;
            $display("FAIL rstmid_fresh_data: got addr=%h i=%h, want addr=%h i=%h",
                     o.addr, o.i_rdata, e.addr, e.line);
        end
        @(posedge clk); #1;
        bus.i_read = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        gap         = 0;
        rst         = 1'b1;
        bus.i_addr  = 32'h0;
        bus.i_read  = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_wdata = '0;
        model_i     = '0;
        model_d     = '0;
        rd_beats    = '{64'h0, 64'h0, 64'h0, 64'h0};

        test_reset();
        test_icache_read();
        test_dcache_write();
        test_conflict();
        test_stall();
        test_simultaneous();
        test_reset_mid_burst();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
